handshake_responder: RTL and testbench

Consumer side of the per-channel trigger handshake. It watches the `N_CH` level handshake flags raised by the channel monostables and groups flags that arrive within a coincidence window into one event. It presents the hit mask and timestamp on a valid/ready output toward the event FIFO. After acceptance it drives a clear pulse back to every monostable, then holds a programmable dead time before re-arming.

---
 rtl/handshake_pkg.sv | 27 ++
 rtl/handshake_responder_phase_counter.sv | 27 ++
 rtl/handshake_responder.sv | 159 +++++++++++++++
 tb/tb_handshake_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared types, default widths and helpers for the trigger handshake responder.
package handshake_pkg;

    localparam int N_CH   = 4;
    localparam int TS_W   = 32;
    localparam int DEAD_W = 16;

    localparam logic [15:0] LOST_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_OUTPUT,
        S_CLEAR,
        S_DEAD
    } resp_state_t;

    function automatic logic [5:0] count_ones(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/handshake_responder_phase_counter.sv
// Loadable down-counter; done marks the final cycle of the loaded phase length.
module phase_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == W'(1));

endmodule

// File: rtl/handshake_responder.sv
// Groups coincident monostable flags into one event, hands it downstream,
// then clears the monostables and holds off for a programmable dead time.
module handshake_responder #(
    parameter int N_CH    = handshake_pkg::N_CH,
    parameter int TS_W    = handshake_pkg::TS_W,
    parameter int CLEAR_W = 4,
    parameter int DEAD_W  = handshake_pkg::DEAD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   handshake,
    input  logic [TS_W-1:0]   timestamp,
    input  logic [7:0]        coinc_window,
    input  logic [DEAD_W-1:0] dead_time,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [N_CH-1:0]   ev_hitmask,
    output logic [TS_W-1:0]   ev_timestamp,
    output logic [N_CH-1:0]   clear,
    output logic              busy,
    output logic [15:0]       lost_count
);

    import handshake_pkg::*;

    // One counter serves window, clear and dead phases, so it must fit the widest.
    localparam int CNT_W = (DEAD_W > 8) ? DEAD_W : 8;

    resp_state_t       r_state;
    logic [N_CH-1:0]   r_mask;
    logic [N_CH-1:0]   r_hs_prev;
    logic [N_CH-1:0]   r_clear;
    logic [TS_W-1:0]   r_ts;
    logic [DEAD_W-1:0] r_dead;
    logic              r_valid;
    logic [15:0]       r_lost;

    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_load_val;
    logic              w_cnt_en;
    logic              w_cnt_done;
    logic [N_CH-1:0]   w_rise;
    logic [16:0]       w_lost_sum;

    assign w_rise     = handshake & ~r_hs_prev;
    assign w_lost_sum = {1'b0, r_lost} + 17'(count_ones(32'(w_rise)));

    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((handshake != '0) && (coinc_window != 8'd0)) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = CNT_W'(coinc_window);
                end
            end
            S_COLLECT: w_cnt_en = 1'b1;
            S_OUTPUT: begin
                if (ev_ready) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = CNT_W'(CLEAR_W);
                end
            end
            S_CLEAR: begin
                if (w_cnt_done && (r_dead != '0)) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = CNT_W'(r_dead);
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            S_DEAD:  w_cnt_en = 1'b1;
            default: w_cnt_en = 1'b0;
        endcase
    end

    phase_counter #(
        .W(CNT_W)
    ) u_phase_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_done     (w_cnt_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_hs_prev <= '0;
            r_clear   <= '0;
            r_ts      <= '0;
            r_dead    <= '0;
            r_valid   <= 1'b0;
            r_lost    <= '0;
        end else begin
            r_hs_prev <= handshake;

            // Edges while the event is parked or being cleared are swallowed by clear.
            if (((r_state == S_OUTPUT) || (r_state == S_CLEAR)) && (w_rise != '0)) begin
                r_lost <= w_lost_sum[16] ? LOST_MAX : w_lost_sum[15:0];
            end

            case (r_state)
                S_IDLE: begin
                    if (handshake != '0) begin
                        r_ts   <= timestamp;
                        r_mask <= handshake;
                        r_dead <= dead_time;
                        if (coinc_window == 8'd0) begin
                            r_state <= S_OUTPUT;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    r_mask <= r_mask | handshake;
                    if (w_cnt_done) begin
                        r_state <= S_OUTPUT;
                        r_valid <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (ev_ready) begin
                        r_valid <= 1'b0;
                        r_clear <= '1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (w_cnt_done) begin
                        r_clear <= '0;
                        r_state <= (r_dead == '0) ? S_IDLE : S_DEAD;
                    end
                end
                S_DEAD: begin
                    if (w_cnt_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ev_valid     = r_valid;
    assign ev_hitmask   = r_mask;
    assign ev_timestamp = r_ts;
    assign clear        = r_clear;
    assign busy         = (r_state != S_IDLE);
    assign lost_count   = r_lost;

endmodule

// File: tb/tb_handshake_responder.sv
// Directed stimulus with a scoreboard: expected events are queued at issue time
// and a negedge monitor compares every accepted event against the queue head.
module tb_handshake_responder;

    logic        clk;
    logic        reset_n;
    logic [3:0]  handshake;
    logic [31:0] timestamp;
    logic [7:0]  coinc_window;
    logic [15:0] dead_time;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_hitmask;
    logic [31:0] ev_timestamp;
    logic [3:0]  clear;
    logic        busy;
    logic [15:0] lost_count;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] ts;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks   = 0;
    int  failures = 0;

    handshake_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .handshake    (handshake),
        .timestamp    (timestamp),
        .coinc_window (coinc_window),
        .dead_time    (dead_time),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_hitmask   (ev_hitmask),
        .ev_timestamp (ev_timestamp),
        .clear        (clear),
        .busy         (busy),
        .lost_count   (lost_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial timestamp = 32'd1000;
    always @(posedge clk) timestamp <= timestamp + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_event(input logic [3:0] m, input logic [31:0] t);
        ev_t e;
        e.mask = m;
        e.ts   = t;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual mask=%b ts=%0d required=none", ev_hitmask, ev_timestamp);
            end else begin
                mon_e = exp_q.pop_front();
                $display("EVENT mask=%b ts=%0d expected mask=%b ts=%0d",
                         ev_hitmask, ev_timestamp, mon_e.mask, mon_e.ts);
                check("ev_hitmask", 32'(ev_hitmask), 32'(mon_e.mask));
                check("ev_timestamp", ev_timestamp, mon_e.ts);
            end
        end
    end

    logic [31:0] ts0;

    initial begin
        reset_n      = 1'b0;
        handshake    = 4'b0000;
        coinc_window = 8'd0;
        dead_time    = 16'd0;
        ev_ready     = 1'b0;
        cyc(3);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_mask", 32'(ev_hitmask), 32'd0);
        check("rst_ts", ev_timestamp, 32'd0);
        check("rst_lost", 32'(lost_count), 32'd0);
        reset_n = 1'b1;
        cyc(2);

        // Single flag, window 3, dead 5, downstream always ready
        handshake = 4'b0001; coinc_window = 8'd3; dead_time = 16'd5; ev_ready = 1'b1;
        expect_event(4'b0001, timestamp);
        cyc(1);
        check("t1_busy_t1", 32'(busy), 32'd1);
        check("t1_valid_t1", 32'(ev_valid), 32'd0);
        cyc(2);
        check("t1_valid_t3", 32'(ev_valid), 32'd0);
        cyc(1);
        check("t1_valid_t4", 32'(ev_valid), 32'd1);
        check("t1_clear_t4", 32'(clear), 32'd0);
        cyc(1);
        check("t1_clear_t5", 32'(clear), 32'hF);
        handshake = 4'b0000;
        cyc(3);
        check("t1_clear_t8", 32'(clear), 32'hF);
        cyc(1);
        check("t1_clear_t9", 32'(clear), 32'd0);
        check("t1_dead_busy", 32'(busy), 32'd1);
        cyc(4);
        check("t1_busy_t13", 32'(busy), 32'd1);
        cyc(1);
        check("t1_idle_t14", 32'(busy), 32'd0);

        // Two flags inside the window, then a third lost while the event is parked
        handshake = 4'b0001; coinc_window = 8'd3; dead_time = 16'd0; ev_ready = 1'b0;
        expect_event(4'b0101, timestamp);
        cyc(2);
        handshake = 4'b0101;
        cyc(2);
        check("t2_valid", 32'(ev_valid), 32'd1);
        check("t2_mask", 32'(ev_hitmask), 32'h5);
        cyc(1);
        handshake = 4'b1101;
        cyc(1);
        check("t2_lost", 32'(lost_count), 32'd1);
        check("t2_mask_after_late", 32'(ev_hitmask), 32'h5);
        ev_ready = 1'b1;
        cyc(1);
        check("t2_clear", 32'(clear), 32'hF);
        handshake = 4'b0000;
        cyc(4);
        check("t2_idle", 32'(busy), 32'd0);
        check("t2_lost_hold", 32'(lost_count), 32'd1);

        // Backpressure: data and valid must hold, clear must wait for the transfer
        handshake = 4'b0010; coinc_window = 8'd1; dead_time = 16'd2; ev_ready = 1'b0;
        ts0 = timestamp;
        expect_event(4'b0010, ts0);
        cyc(2);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(ev_valid), 32'd1);
            check("t3_hold_mask", 32'(ev_hitmask), 32'h2);
            check("t3_hold_ts", ev_timestamp, ts0);
            check("t3_hold_clear", 32'(clear), 32'd0);
            coinc_window = 8'd7;
            cyc(1);
        end
        ev_ready = 1'b1;
        check("t3_clear_xfer", 32'(clear), 32'd0);
        cyc(1);
        check("t3_clear_after", 32'(clear), 32'hF);
        handshake = 4'b0000;
        cyc(5);
        check("t3_busy_dead", 32'(busy), 32'd1);
        cyc(1);
        check("t3_idle", 32'(busy), 32'd0);

        // Window 0, dead 0, flag still high on IDLE entry: back-to-back events
        handshake = 4'b0010; coinc_window = 8'd0; dead_time = 16'd0; ev_ready = 1'b1;
        expect_event(4'b0010, timestamp);
        cyc(1);
        check("t4_valid1", 32'(ev_valid), 32'd1);
        cyc(5);
        check("t4_idle_gap", 32'(busy), 32'd0);
        expect_event(4'b0010, timestamp);
        cyc(1);
        check("t4_valid2", 32'(ev_valid), 32'd1);
        handshake = 4'b0000;
        cyc(5);
        check("t4_idle_end", 32'(busy), 32'd0);

        // Long run of lost edges drives the counter into saturation
        handshake = 4'b0001; coinc_window = 8'd0; dead_time = 16'd0; ev_ready = 1'b0;
        expect_event(4'b0001, timestamp);
        cyc(1);
        check("t5_valid", 32'(ev_valid), 32'd1);
        for (int i = 0; i < 16379; i++) begin
            handshake = 4'b0000;
            cyc(1);
            handshake = 4'b1111;
            cyc(1);
        end
        check("t5_near_max", 32'(lost_count), 32'hFFED);
        for (int i = 0; i < 4; i++) begin
            handshake = 4'b0000;
            cyc(1);
            handshake = 4'b1111;
            cyc(1);
        end
        check("t5_fffd", 32'(lost_count), 32'hFFFD);
        handshake = 4'b0000;
        cyc(1);
        handshake = 4'b1111;
        cyc(1);
        check("t5_saturate", 32'(lost_count), 32'hFFFF);
        handshake = 4'b0000;
        cyc(1);
        handshake = 4'b1111;
        cyc(1);
        check("t5_no_wrap", 32'(lost_count), 32'hFFFF);
        ev_ready = 1'b1;
        cyc(1);
        handshake = 4'b0000;
        cyc(4);
        check("t5_idle", 32'(busy), 32'd0);

        // Reset during CLEAR, released with flags still set
        handshake = 4'b0001; coinc_window = 8'd0; dead_time = 16'd0; ev_ready = 1'b1;
        expect_event(4'b0001, timestamp);
        cyc(2);
        check("t6_clear_before", 32'(clear), 32'hF);
        reset_n   = 1'b0;
        handshake = 4'b0011;
        #1;
        check("t6_clear_async", 32'(clear), 32'd0);
        check("t6_valid_rst", 32'(ev_valid), 32'd0);
        check("t6_busy_rst", 32'(busy), 32'd0);
        check("t6_mask_rst", 32'(ev_hitmask), 32'd0);
        check("t6_ts_rst", ev_timestamp, 32'd0);
        check("t6_lost_rst", 32'(lost_count), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        expect_event(4'b0011, timestamp);
        cyc(1);
        check("t6_busy_new", 32'(busy), 32'd1);
        check("t6_valid_new", 32'(ev_valid), 32'd1);
        check("t6_mask_new", 32'(ev_hitmask), 32'h3);
        cyc(1);
        handshake = 4'b0000;
        cyc(5);
        check("t6_idle", 32'(busy), 32'd0);

        cyc(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
